// File: rtl/depuncturer.sv
// Depuncturer: rebuilds rate-1/2 (y1,y2) soft pairs from a punctured 3-bit symbol stream (1/2, 2/3, 3/4).
// Rate 3/4 is compiled in only when DEPUNCT_RATE34_EN is defined; outputs are registered (1-cycle latency), no backpressure.
module depuncturer #(
  parameter logic [2:0] ERASE_VAL = 3'd4,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       in_sym,
  input  logic             frame_start,
  input  logic [1:0]       rate_sel,
  input  logic             flush,
  output logic [2:0]       y1,
  output logic [2:0]       y2,
  output logic             enable,
  output logic [CNT_W-1:0] frame_pairs,
  output logic             rate_err
);

  localparam logic [1:0] RATE12 = 2'd0;
  localparam logic [1:0] RATE23 = 2'd1;
`ifdef DEPUNCT_RATE34_EN
  localparam logic [1:0] RATE34 = 2'd2;
`endif

  logic [1:0]       rate_q, rate_d;
  logic [1:0]       phase_q, phase_d;
  logic [2:0]       hold_q, hold_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       y1_q, y1_d, y2_q, y2_d;
  logic             en_q, en_d;

  logic [1:0] sel_rate;
  logic       sel_ok;
  logic [1:0] cur_rate;
  logic [1:0] cur_phase;
  logic       count;

  function automatic logic [1:0] last_phase(input logic [1:0] r);
    case (r)
      RATE23:  return 2'd2;
`ifdef DEPUNCT_RATE34_EN
      RATE34:  return 2'd3;
`endif
      default: return 2'd1;
    endcase
  endfunction

  always_comb begin
    sel_rate = RATE12;
    sel_ok   = 1'b1;
    case (rate_sel)
      2'b00:   sel_rate = RATE12;
      2'b01:   sel_rate = RATE23;
`ifdef DEPUNCT_RATE34_EN
      2'b10:   sel_rate = RATE34;
`endif
      default: sel_ok = 1'b0;
    endcase
  end

  always_comb begin
    rate_d    = rate_q;
    phase_d   = phase_q;
    hold_d    = hold_q;
    pend_d    = pend_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    en_d      = 1'b0;
    count     = 1'b0;
    cur_rate  = rate_q;
    cur_phase = phase_q;

    // Boundary stage: a frame restart or flush closes out a half-filled pair first.
    if (in_valid && frame_start) begin
      cur_rate  = sel_rate;
      cur_phase = 2'd0;
      rate_d    = sel_rate;
      cnt_d     = '0;
      if (!sel_ok) err_d = 1'b1;
      if (pend_q) begin
        en_d = 1'b1;
        y1_d = hold_q;
        y2_d = ERASE_VAL;
      end
      pend_d  = 1'b0;
      phase_d = 2'd0;
    end else if (flush) begin
      if (pend_q) begin
        en_d    = 1'b1;
        count   = 1'b1;
        y1_d    = hold_q;
        y2_d    = ERASE_VAL;
        pend_d  = 1'b0;
        phase_d = 2'd0;
      end
      if (in_valid) cur_phase = 2'd0;
    end

    if (in_valid) begin
      phase_d = (cur_phase == last_phase(cur_rate)) ? 2'd0 : 2'(cur_phase + 2'd1);
      case (cur_phase)
        2'd0: begin
          hold_d = in_sym;
          pend_d = 1'b1;
        end
        2'd1: begin
          en_d   = 1'b1;
          count  = 1'b1;
          y1_d   = hold_q;
          y2_d   = in_sym;
          pend_d = 1'b0;
        end
        2'd2: begin
          en_d  = 1'b1;
          count = 1'b1;
`ifdef DEPUNCT_RATE34_EN
          if (cur_rate == RATE34) begin
            y1_d = ERASE_VAL;
            y2_d = in_sym;
          end else begin
            y1_d = in_sym;
            y2_d = ERASE_VAL;
          end
`else
          y1_d = in_sym;
          y2_d = ERASE_VAL;
`endif
        end
`ifdef DEPUNCT_RATE34_EN
        2'd3: begin
          en_d  = 1'b1;
          count = 1'b1;
          y1_d  = in_sym;
          y2_d  = ERASE_VAL;
        end
`endif
        default: ;
      endcase
    end

    if (count && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate_q  <= RATE12;
      phase_q <= 2'd0;
      hold_q  <= 3'd0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      y1_q    <= 3'd0;
      y2_q    <= 3'd0;
      en_q    <= 1'b0;
    end else begin
      rate_q  <= rate_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      en_q    <= en_d;
    end
  end

  assign y1          = y1_q;
  assign y2          = y2_q;
  assign enable      = en_q;
  assign frame_pairs = cnt_q;
  assign rate_err    = err_q;

endmodule

// File: tb/tb_depuncturer.sv
// Bench for depuncturer: puncture-matrix reference model, directed scenarios plus random traffic.
// Built with or without DEPUNCT_RATE34_EN; expectations follow the macro.
module tb_depuncturer;

  localparam int         TB_CNT_W = 4;
  localparam int         CMAX     = (1 << TB_CNT_W) - 1;
  localparam logic [2:0] E        = 3'd4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                in_valid = 1'b0;
  logic [2:0]          in_sym = 3'd0;
  logic                frame_start = 1'b0;
  logic [1:0]          rate_sel = 2'd0;
  logic                flush = 1'b0;
  logic [2:0]          y1, y2;
  logic                enable;
  logic [TB_CNT_W-1:0] frame_pairs;
  logic                rate_err;

  int vectors = 0;
  int miscompares = 0;

  depuncturer #(.ERASE_VAL(E), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sym(in_sym),
    .frame_start(frame_start), .rate_sel(rate_sel), .flush(flush),
    .y1(y1), .y2(y2), .enable(enable), .frame_pairs(frame_pairs), .rate_err(rate_err)
  );

  always #5 clk = ~clk;

  // Transmission order within one puncturing period: which pair and which slot (0=y1, 1=y2) each symbol fills.
  int plen [3]    = '{2, 3, 4};
  int ppair[3][4] = '{'{0, 0, 0, 0}, '{0, 0, 1, 0}, '{0, 0, 1, 2}};
  int pslot[3][4] = '{'{0, 1, 0, 0}, '{0, 1, 0, 0}, '{0, 1, 1, 0}};

  int         m_rate, m_k, m_open;
  logic [2:0] m_slot[3][2];
  logic       e_en, e_err;
  logic [2:0] e_y1, e_y2;
  int         e_cnt;

  logic [11:0] dut_vec;
  assign dut_vec = {enable, y1, y2, frame_pairs, rate_err};

  function automatic logic [11:0] exp_vec();
    return {e_en, e_y1, e_y2, TB_CNT_W'(e_cnt), e_err};
  endfunction

  function automatic int rate_map(input logic [1:0] rs);
    if (rs == 2'd1) return 1;
`ifdef DEPUNCT_RATE34_EN
    if (rs == 2'd2) return 2;
`endif
    return 0;
  endfunction

  task automatic model_reset();
    m_rate = 0; m_k = 0; m_open = -1;
    e_en = 0; e_y1 = 0; e_y2 = 0; e_cnt = 0; e_err = 0;
  endtask

  task automatic model_emit(input int p, input bit counted);
    e_en = 1; e_y1 = m_slot[p][0]; e_y2 = m_slot[p][1];
    if (counted && e_cnt < CMAX) e_cnt++;
  endtask

  task automatic model_step(input bit v, input logic [2:0] s, input bit fs, input logic [1:0] rs, input bit fl);
    int p;
    e_en = 0;
    if (v && fs) begin
      if (m_open >= 0) model_emit(m_open, 0);
      m_rate = rate_map(rs);
      if (rs == 2'd3 || (rs == 2'd2 && m_rate == 0)) e_err = 1;
      e_cnt = 0; m_k = 0; m_open = -1;
    end else if (fl && m_open >= 0) begin
      model_emit(m_open, 1);
      m_k = 0; m_open = -1;
    end
    if (v) begin
      if (fl) m_k = 0;
      p = ppair[m_rate][m_k];
      if (m_k == 0 || ppair[m_rate][m_k-1] != p) begin
        m_slot[p][0] = E; m_slot[p][1] = E;
      end
      m_slot[p][pslot[m_rate][m_k]] = s;
      if (m_k == plen[m_rate] - 1 || ppair[m_rate][m_k+1] != p) begin
        model_emit(p, 1); m_open = -1;
      end else begin
        m_open = p;
      end
      m_k = (m_k + 1) % plen[m_rate];
    end
  endtask

  task automatic apply(input bit v, input logic [2:0] s, input bit fs, input logic [1:0] rs, input bit fl);
    @(negedge clk);
    in_valid = v; in_sym = s; frame_start = fs; rate_sel = rs; flush = fl;
    model_step(v, s, fs, rs, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0; frame_start = 0; flush = 0;
    rst = 1; model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    apply(1, 3'd5, 1, 2'd3, 0);
    apply(1, 3'd6, 0, 2'd0, 0);
    @(negedge clk);
    in_valid = 0;
    #2 rst = 1;
    #1 model_reset();
    vectors++;
    if (dut_vec !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_state got=%h exp=000", dut_vec);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_rate12();
    logic [5:0] got[$];
    logic [5:0] exp_p[$];
    logic [2:0] syms[4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    do_reset();
    foreach (syms[i]) begin
      apply(1, syms[i], i == 0, 2'd0, 0);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL rate12 step%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      if (enable) got.push_back({y1, y2});
    end
    exp_p = '{6'o12, 6'o34};
    vectors++;
    if (got != exp_p || frame_pairs !== 4'd2) begin
      miscompares++;
      $display("FAIL rate12_pairs got=%p fp=%0d exp=%p fp=2", got, frame_pairs, exp_p);
    end
  endtask

  task automatic test_rate23();
    logic [5:0] got[$];
    logic [5:0] exp_p[$];
    logic [2:0] syms[6] = '{3'd7, 3'd0, 3'd5, 3'd6, 3'd1, 3'd2};
    do_reset();
    foreach (syms[i]) begin
      apply(1, syms[i], i == 0, 2'd1, 0);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL rate23 step%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      if (enable) got.push_back({y1, y2});
    end
    exp_p = '{6'o70, 6'o54, 6'o61, 6'o24};
    vectors++;
    if (got != exp_p || frame_pairs !== 4'd4) begin
      miscompares++;
      $display("FAIL rate23_pairs got=%p fp=%0d exp=%p fp=4", got, frame_pairs, exp_p);
    end
  endtask

  task automatic test_rate34();
    logic [5:0] got[$];
    logic [5:0] exp_p[$];
    logic       exp_err;
    logic [2:0] syms[4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    do_reset();
    foreach (syms[i]) begin
      apply(1, syms[i], i == 0, 2'd2, 0);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL rate34 step%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      if (enable) got.push_back({y1, y2});
    end
`ifdef DEPUNCT_RATE34_EN
    exp_p = '{6'o12, 6'o43, 6'o44};
    exp_err = 1'b0;
`else
    exp_p = '{6'o12, 6'o34};
    exp_err = 1'b1;
`endif
    vectors++;
    if (got != exp_p || rate_err !== exp_err) begin
      miscompares++;
      $display("FAIL rate34_pairs got=%p err=%b exp=%p err=%b", got, rate_err, exp_p, exp_err);
    end
  endtask

  task automatic test_flush_boundary();
    logic [5:0] got[$];
    logic [5:0] exp_p[$];
    // {valid, sym, frame_start, flush}
    logic [5:0] stim[8] = '{{1'b1, 3'd5, 1'b1, 1'b0}, {1'b1, 3'd6, 1'b0, 1'b0}, {1'b1, 3'd7, 1'b0, 1'b0},
                            {1'b1, 3'd1, 1'b1, 1'b0}, {1'b1, 3'd2, 1'b0, 1'b0}, {1'b0, 3'd0, 1'b0, 1'b1},
                            {1'b1, 3'd3, 1'b0, 1'b0}, {1'b0, 3'd0, 1'b0, 1'b1}};
    do_reset();
    foreach (stim[i]) begin
      apply(stim[i][5], stim[i][4:2], stim[i][1], 2'd0, stim[i][0]);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL flush step%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      if (i == 3) begin
        vectors++;
        if (frame_pairs !== 4'd0 || enable !== 1'b1) begin
          miscompares++;
          $display("FAIL restart_count got fp=%0d en=%b exp fp=0 en=1", frame_pairs, enable);
        end
      end
      if (i == 5) begin
        vectors++;
        if (enable !== 1'b0) begin
          miscompares++;
          $display("FAIL idle_flush got en=%b exp en=0", enable);
        end
      end
      if (enable) got.push_back({y1, y2});
    end
    exp_p = '{6'o56, 6'o74, 6'o12, 6'o34};
    vectors++;
    if (got != exp_p) begin
      miscompares++;
      $display("FAIL flush_pairs got=%p exp=%p", got, exp_p);
    end
  endtask

  task automatic test_gaps();
    logic [5:0] got[$];
    logic [5:0] exp_p[$];
    logic [3:0] stim[6] = '{{1'b1, 3'd3}, {1'b0, 3'd1}, {1'b0, 3'd2}, {1'b0, 3'd7}, {1'b1, 3'd4}, {1'b1, 3'd5}};
    do_reset();
    foreach (stim[i]) begin
      apply(stim[i][3], stim[i][2:0], i == 0, 2'd1, 0);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL gaps step%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      if (enable) got.push_back({y1, y2});
    end
    exp_p = '{6'o34, 6'o54};
    vectors++;
    if (got != exp_p) begin
      miscompares++;
      $display("FAIL gaps_pairs got=%p exp=%p", got, exp_p);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] syms[2] = '{3'd1, 3'd2};
    do_reset();
    apply(1, 3'd6, 1, 2'd1, 0);
    do_reset();
    foreach (syms[i]) begin
      apply(1, syms[i], 0, 2'd0, 0);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_mid step%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    vectors++;
    if ({y1, y2} !== 6'o12) begin
      miscompares++;
      $display("FAIL reset_mid_pair got=%o exp=12", {y1, y2});
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      apply(1, 3'($urandom_range(0, 7)), i == 0, 2'd0, 0);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL saturation step%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    vectors++;
    if (frame_pairs !== 4'd15) begin
      miscompares++;
      $display("FAIL saturation_final got=%0d exp=15", frame_pairs);
    end
  endtask

  task automatic test_reserved();
    do_reset();
    apply(1, 3'd2, 1, 2'd3, 0);
    apply(1, 3'd3, 0, 2'd0, 0);
    vectors++;
    if (dut_vec !== exp_vec() || rate_err !== 1'b1 || {y1, y2} !== 6'o23) begin
      miscompares++;
      $display("FAIL reserved_rate got=%h exp=%h", dut_vec, exp_vec());
    end
    apply(1, 3'd0, 1, 2'd0, 0);
    apply(1, 3'd1, 0, 2'd0, 0);
    vectors++;
    if (rate_err !== 1'b1) begin
      miscompares++;
      $display("FAIL reserved_sticky got=%b exp=1", rate_err);
    end
    do_reset();
    vectors++;
    if (rate_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reserved_clear got=%b exp=0", rate_err);
    end
  endtask

  task automatic test_random();
    bit v, fs, fl;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v  = $urandom_range(0, 3) != 0;
      fs = ($urandom_range(0, 19) == 0) || (i == 0);
      fl = $urandom_range(0, 14) == 0;
      apply(v, 3'($urandom_range(0, 7)), fs, 2'($urandom_range(0, 2)), fl);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    rst = 1;
    #12 rst = 0;
    test_reset();
    test_rate12();
    test_rate23();
    test_rate34();
    test_flush_boundary();
    test_gaps();
    test_reset_mid();
    test_saturation();
    test_reserved();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/depuncturer.md
# depuncturer

- Rebuilds the rate-1/2 soft-symbol pair stream the Viterbi decoder consumes from a punctured serial channel stream.
- Accepts one 3-bit soft symbol per cycle and re-inserts erasure symbols at punctured positions.
- Emits one (y1, y2) pair with a one-cycle enable strobe, driving the decoder's enable/y1/y2 inputs directly.
- Supports rates 1/2, 2/3 and 3/4; tracks frame boundaries and counts output pairs per frame.

## Interface
- ERASE_VAL, default 3'd4: soft value inserted at punctured positions (neutral point of the 3-bit offset-binary scale).
- CNT_W, default 16: width of the frame pair counter.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_sym is valid this cycle; no backpressure.
- in_sym  in  3  soft channel symbol, offset binary (0 = strong 0, 7 = strong 1).
- frame_start  in  1  qualified by in_valid; marks this symbol as first of a frame.
- rate_sel  in  2  code rate: 00 = 1/2, 01 = 2/3, 10 = 3/4, 11 = reserved. Sampled only on frame_start.
- flush  in  1  emit any half-filled pair with an erasure in the y2 slot.
- y1  out  3  first soft symbol of output pair.
- y2  out  3  second soft symbol of output pair.
- enable  out  1  one-cycle strobe; y1/y2 valid.
- frame_pairs  out  CNT_W  pairs emitted since last frame_start; saturates at all-ones.
- rate_err  out  1  sticky; latched rate_sel was reserved or unsupported. Cleared only by rst.

## Operation
- Registers:
  - rate_q: latched rate.
  - phase: pattern position.
  - hold: stored c1 symbol.
  - pend: hold is valid.
- Pattern length: 2 / 3 / 4 symbols for rate 1/2 / 2/3 / 3/4. Input symbol s is handled per phase:
  - Rate 1/2:
    - ph0: hold <= s, pend = 1.
    - ph1: emit (hold, s).
  - Rate 2/3:
    - ph0: store.
    - ph1: emit (hold, s).
    - ph2: emit (s, E).
  - Rate 3/4:
    - ph0: store.
    - ph1: emit (hold, s).
    - ph2: emit (E, s).
    - ph3: emit (s, E).
  - E = ERASE_VAL.
  - phase wraps to 0 after the last position.
  - pend clears on every emit.
- frame_start with in_valid:
  - rate_q <= rate_sel.
  - If pend, emit (hold, E) this cycle.
  - The symbol is processed as ph0: it is stored and phase becomes 1.
  - frame_pairs loads 0; the flushed pair is not counted.
- Reserved rate_sel = 11: rate_q = 1/2 and rate_err <= 1.
- flush without in_valid:
  - If pend, emit (hold, E), pend = 0, phase = 0.
  - Otherwise no effect.
- flush with in_valid and no frame_start:
  - Flush first (emit if pend).
  - The symbol is then processed as ph0 under the current rate_q.
- Symbols arriving before the first frame_start use the reset rate (1/2).
- frame_pairs increments on each emit (except a frame_start flush); holds at 2^CNT_W-1.

## Timing
- Reset values:
  - y1 = 0, y2 = 0, enable = 0, frame_pairs = 0, rate_err = 0.
  - phase = 0, pend = 0, rate_q = 1/2.
- Latency: y1/y2/enable are registered, so enable asserts the cycle after the completing symbol (or flush) is sampled.
- At most one pair per cycle. Every input event produces at most one emit, so no overflow is possible.
- y1/y2 hold their last value while enable = 0.
- rst mid-pattern: pending hold is discarded and no pair is emitted.
- in_valid = 0 cycles freeze phase and hold. Gaps of any length are legal.

## Configuration
- DEPUNCT_RATE34_EN defined: rate 3/4 logic is compiled in.
- DEPUNCT_RATE34_EN undefined:
  - rate_sel = 10 is treated like reserved: rate_q = 1/2, rate_err <= 1.
  - The 4-phase path is removed; phase counter width is 2 bits max.

## Test plan
- Rate 1/2: frame_start + symbols 1,2,3,4 back-to-back -> enable on cycles 2 and 4 after first sample, pairs (1,2),(3,4); frame_pairs = 2.
- Rate 2/3: symbols 7,0,5,6,1,2 -> pairs (7,0),(5,4),(6,1),(2,4); frame_pairs = 4.
- Rate 3/4 (macro defined): symbols 1,2,3,4 -> pairs (1,2),(4,3),(4,4)... precisely (1,2),(E=4,3),(4,E=4); same stream with macro undefined and rate_sel = 10 -> rate_err = 1, pairs (1,2),(3,4).
- Flush/frame boundary:
  - Rate 1/2, symbols 5,6,7, then frame_start with symbol 1 -> (5,6), then (7,4) emitted, frame_pairs reads 0 after restart.
  - flush alone with pend = 0 -> no enable.
- Idle gaps and reset: rate 2/3 symbols 3,[3 idle cycles],4,5 -> (3,4),(5,4) unchanged. Assert rst after one stored symbol -> no emit, all outputs 0, next pair starts at ph0.
- Saturation: CNT_W = 4, rate 1/2, 40 symbols -> frame_pairs stops at 15. Reserved rate_sel = 11 -> rate_err sticks until rst.
